// File: rtl/multi_clk_div.sv
// multi_clk_div: NCH independent programmable clock dividers sharing one system clock.
//   clock, reset    : system clock, synchronous active-high reset
//   enable          : per-channel run enable
//   cfg_we/ch/half  : half-period write (length = cfg_half+1 cycles)
//   sync_restart    : realign all channels to cnt=0, clk_out=OUT_INIT
//   clk_out, tick   : registered divided clocks and per-toggle pulses
//   cfg_pending     : a written half-period waits for the next terminal count
module multi_clk_div #(
  parameter int unsigned   NCH          = 2,
  parameter int unsigned   CW           = 25,
  parameter logic [CW-1:0] DEFAULT_HALF = CW'(24999999),
  parameter bit            OUT_INIT     = 1'b1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NCH-1:0]                          enable,
  input  logic                                    cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [CW-1:0]                           cfg_half,
  input  logic                                    sync_restart,
  output logic [NCH-1:0]                          clk_out,
  output logic [NCH-1:0]                          tick,
  output logic [NCH-1:0]                          cfg_pending
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  half_q [NCH];
  logic [CW-1:0]  half_d [NCH];
  logic [CW-1:0]  shad_q [NCH];
  logic [CW-1:0]  shad_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] clk_q, clk_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] hit;

  // Out-of-range cfg_ch never matches any channel index, so it is ignored.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      hit[i] = cfg_we && (cfg_ch == CHW'(i));
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    shad_d = shad_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sync_restart) begin
        cnt_d[i] = '0;
        clk_d[i] = OUT_INIT;
        pend_d[i] = 1'b0;
        if (hit[i]) begin
          half_d[i] = cfg_half;
        end else if (pend_q[i]) begin
          half_d[i] = shad_q[i];
        end
      end else if (enable[i]) begin
        if (cnt_q[i] == half_q[i]) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
          pend_d[i] = 1'b0;
          if (hit[i]) begin
            half_d[i] = cfg_half;
          end else if (pend_q[i]) begin
            half_d[i] = shad_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
          if (hit[i]) begin
            shad_d[i] = cfg_half;
            pend_d[i] = 1'b1;
          end
        end
      end else if (hit[i]) begin
        half_d[i] = cfg_half;
        cnt_d[i]  = '0;
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        half_q[i] <= DEFAULT_HALF;
        shad_q[i] <= '0;
      end
      pend_q <= '0;
      clk_q  <= {NCH{OUT_INIT}};
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      shad_q <= shad_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick        = tick_q;
  assign cfg_pending = pend_q;

endmodule
